button_event_detector: RTL and testbench



---
 rtl/button_event_detector.sv | 135 +++++++++++++
 tb/tb_button_event_detector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_detector.sv
// button_event_detector
//   Turns the debounced button level into single-cycle event strobes
//   (press, release, long-press, auto-repeat), a held level and a wrapping
//   8-bit press counter. All outputs come straight from flops.
//
// Ports:
//   clk_25M           in   system clock
//   reset_n           in   asynchronous active-low reset
//   btn_level         in   debounced button level, 1 = pressed
//   press_pulse       out  one-cycle strobe on press
//   release_pulse     out  one-cycle strobe on release
//   long_press_pulse  out  one-cycle strobe after LONG_COUNT cycles of hold
//   repeat_pulse      out  one-cycle strobe every REPEAT_COUNT cycles in long hold
//   held              out  1 while the button is considered held
//   press_count       out  presses since reset, wraps at 256
module button_event_detector #(
   parameter int unsigned LONG_COUNT   = 25_000_000,
   parameter int unsigned REPEAT_COUNT = 5_000_000,
   parameter int unsigned CNT_W        = 25
) (
   input  logic       clk_25M,
   input  logic       reset_n,
   input  logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_press_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] press_count
);

   localparam int unsigned PCNT_W = 8;
   localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_COUNT - 1);
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PCNT_W-1:0]   press_count_q, press_count_d;
   logic                press_q, press_d;
   logic                release_q, release_d;
   logic                long_q, long_d;
   logic                repeat_q, repeat_d;
   logic                held_q, held_d;

   // State register and registered outputs
   always_ff @(posedge clk_25M or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         press_count_q <= '0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         long_q        <= 1'b0;
         repeat_q      <= 1'b0;
         held_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         press_count_q <= press_count_d;
         press_q       <= press_d;
         release_q     <= release_d;
         long_q        <= long_d;
         repeat_q      <= repeat_d;
         held_q        <= held_d;
      end
   end

   // Next-state and pulse logic; release has priority over terminal counts
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      press_count_d = press_count_q;
      press_d       = 1'b0;
      release_d     = 1'b0;
      long_d        = 1'b0;
      repeat_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (btn_level) begin
               state_d       = ST_PRESSED;
               cnt_d         = '0;
               press_count_d = press_count_q + PCNT_W'(1);
               press_d       = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!btn_level) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (cnt_q == LONG_TC) begin
               state_d = ST_LONG;
               cnt_d   = '0;
               long_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LONG: begin
            if (!btn_level) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (cnt_q == REPEAT_TC) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // held mirrors the state the FSM enters on this edge
      held_d = (state_d != ST_IDLE);
   end

   assign press_pulse      = press_q;
   assign release_pulse    = release_q;
   assign long_press_pulse = long_q;
   assign repeat_pulse     = repeat_q;
   assign held             = held_q;
   assign press_count      = press_count_q;

endmodule

// File: tb/tb_button_event_detector.sv
// Directed testbench for button_event_detector (LONG_COUNT=10, REPEAT_COUNT=4).
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_button_event_detector;

   logic       clk_25M = 1'b0;
   logic       reset_n;
   logic       btn_level;
   logic       press_pulse, release_pulse, long_press_pulse, repeat_pulse, held;
   logic [7:0] press_count;

   int checks   = 0;
   int failures = 0;

   // {press, release, long, repeat, held}
   logic [4:0] ev;
   assign ev = {press_pulse, release_pulse, long_press_pulse, repeat_pulse, held};

   button_event_detector #(
      .LONG_COUNT  (10),
      .REPEAT_COUNT(4),
      .CNT_W       (8)
   ) dut (
      .clk_25M         (clk_25M),
      .reset_n         (reset_n),
      .btn_level       (btn_level),
      .press_pulse     (press_pulse),
      .release_pulse   (release_pulse),
      .long_press_pulse(long_press_pulse),
      .repeat_pulse    (repeat_pulse),
      .held            (held),
      .press_count     (press_count)
   );

   always #5 clk_25M = ~clk_25M;

   task automatic test_reset();
      reset_n   = 1'b0;
      btn_level = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_25M);
         checks++;
         if (ev !== 5'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold i=%0d ev=%b cnt=%0d want ev=00000 cnt=0", i, ev, press_count);
         end
         btn_level = ~btn_level;
      end
      btn_level = 1'b0;
      reset_n   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_25M);
         checks++;
         if (ev !== 5'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_release i=%0d ev=%b cnt=%0d want ev=00000 cnt=0", i, ev, press_count);
         end
      end
   endtask

   // btn high on edges ending P..P+3, low from edge ending P+4
   task automatic test_short_press();
      logic [4:0] exp;
      @(negedge clk_25M);
      btn_level = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_25M);
         exp = {k == 0, k == 5, 1'b0, 1'b0, k < 5};
         checks++;
         if (ev !== exp || press_count !== 8'd1) begin
            failures++;
            $display("FAIL short_press k=%0d ev=%b cnt=%0d want ev=%b cnt=1", k, ev, press_count, exp);
         end
         btn_level = (k < 4);
      end
   endtask

   // btn high through edge ending P+28, low on edge ending P+29 (a repeat terminal edge)
   task automatic test_long_press();
      logic [4:0] exp;
      @(negedge clk_25M);
      btn_level = 1'b1;
      for (int k = 0; k < 33; k++) begin
         @(negedge clk_25M);
         exp = {k == 0, k == 30, k == 10,
                (k == 14 || k == 18 || k == 22 || k == 26), k < 30};
         checks++;
         if (ev !== exp || press_count !== 8'd2) begin
            failures++;
            $display("FAIL long_press k=%0d ev=%b cnt=%0d want ev=%b cnt=2", k, ev, press_count, exp);
         end
         checks++;
         if ($countones(ev[4:1]) > 1) begin
            failures++;
            $display("FAIL one_pulse k=%0d pulses=%b want at most one high", k, ev[4:1]);
         end
         btn_level = (k < 29);
      end
   endtask

   // low sampled on edge ending P+9, where the long terminal count would fire
   task automatic test_release_at_terminal();
      logic [4:0] exp;
      @(negedge clk_25M);
      btn_level = 1'b1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk_25M);
         exp = {k == 0, k == 10, 1'b0, 1'b0, k < 10};
         checks++;
         if (ev !== exp || press_count !== 8'd3) begin
            failures++;
            $display("FAIL release_at_tc k=%0d ev=%b cnt=%0d want ev=%b cnt=3", k, ev, press_count, exp);
         end
         btn_level = (k < 9);
      end
   endtask

   // 257 one-cycle presses with one-cycle gaps after a fresh reset
   task automatic test_back_to_back();
      logic [7:0] exp_cnt;
      @(negedge clk_25M);
      btn_level = 1'b0;
      reset_n   = 1'b0;
      @(negedge clk_25M);
      reset_n = 1'b1;
      @(negedge clk_25M);
      btn_level = 1'b1;
      for (int i = 0; i < 257; i++) begin
         exp_cnt = 8'((i + 1) % 256);
         @(negedge clk_25M);
         checks++;
         if (ev !== 5'b10001 || press_count !== exp_cnt) begin
            failures++;
            $display("FAIL b2b_press i=%0d ev=%b cnt=%0d want ev=10001 cnt=%0d", i, ev, press_count, exp_cnt);
         end
         btn_level = 1'b0;
         @(negedge clk_25M);
         checks++;
         if (ev !== 5'b01000 || press_count !== exp_cnt) begin
            failures++;
            $display("FAIL b2b_release i=%0d ev=%b cnt=%0d want ev=01000 cnt=%0d", i, ev, press_count, exp_cnt);
         end
         btn_level = (i < 256);
      end
      @(negedge clk_25M);
      checks++;
      if (ev !== 5'b0 || press_count !== 8'd1) begin
         failures++;
         $display("FAIL wrap_final ev=%b cnt=%0d want ev=00000 cnt=1", ev, press_count);
      end
   endtask

   // Reset asserted while a repeat pulse is high, button kept down throughout
   task automatic test_reset_mid_long();
      @(negedge clk_25M);
      btn_level = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk_25M);
         if (k == 0) begin
            checks++;
            if (ev !== 5'b10001 || press_count !== 8'd2) begin
               failures++;
               $display("FAIL mid_press ev=%b cnt=%0d want ev=10001 cnt=2", ev, press_count);
            end
         end
         if (k == 10) begin
            checks++;
            if (ev !== 5'b00101) begin
               failures++;
               $display("FAIL mid_long ev=%b want 00101", ev);
            end
         end
         if (k == 14) begin
            checks++;
            if (ev !== 5'b00011) begin
               failures++;
               $display("FAIL mid_repeat ev=%b want 00011", ev);
            end
         end
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (ev !== 5'b0 || press_count !== 8'd0) begin
         failures++;
         $display("FAIL async_clear ev=%b cnt=%0d want ev=00000 cnt=0", ev, press_count);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_25M);
         checks++;
         if (ev !== 5'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL in_reset i=%0d ev=%b cnt=%0d want ev=00000 cnt=0", i, ev, press_count);
         end
      end
      reset_n = 1'b1;
      @(negedge clk_25M);
      checks++;
      if (ev !== 5'b10001 || press_count !== 8'd1) begin
         failures++;
         $display("FAIL post_reset_press ev=%b cnt=%0d want ev=10001 cnt=1", ev, press_count);
      end
      btn_level = 1'b0;
      @(negedge clk_25M);
      checks++;
      if (ev !== 5'b01000 || press_count !== 8'd1) begin
         failures++;
         $display("FAIL post_reset_release ev=%b cnt=%0d want ev=01000 cnt=1", ev, press_count);
      end
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_press();
      test_release_at_terminal();
      test_back_to_back();
      test_reset_mid_long();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
